// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Turns single read/write commands into APB transfers, one outstanding at a time.
//   FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//
// Parameters
//   TIMEOUT_CYCLES : 1..65535, number of consecutive ACCESS cycles with PREADY low
//                    before the transfer is aborted (timeout build only)
//
// Ports
//   clk_in, reset_int                        : clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready, cmd_write/addr/wdata : command handshake and payload
//   rsp_valid/rsp_ready, rsp_rdata/err/timeout: response handshake and payload
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE          : APB requester outputs
//   PRDATA/PREADY/PSLVERR                     : APB completer inputs
//   busy                                      : high whenever not IDLE
//
// Build option
//   APB_MASTER_TIMEOUT_EN : when defined, a 16-bit wait counter aborts ACCESS after
//   TIMEOUT_CYCLES stalled cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   When undefined, ACCESS waits forever and rsp_timeout is tied low.
module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_int,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic [16:0] cnt_inc;
  logic        to_hit;

  // One extra bit so the compare cannot wrap at 65535.
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  assign to_hit  = cnt_inc >= 17'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completion that lands on the timeout cycle still wins.
        if (PREADY) begin
          rdata_d = pwrite_q ? 32'd0 : PRDATA;
          err_d   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (to_hit) begin
          cnt_d   = cnt_inc[15:0];
          rdata_d = 32'd0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_inc[15:0];
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  // All outputs are straight decodes of registered state/payload.
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign rsp_valid = (state_q == RESP);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master; expected responses go through a scoreboard queue.
module tb_apb_cmd_master;

  logic        clk_in = 1'b0;
  logic        reset_int = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR, PWDATA, PRDATA = '0;
  logic        PWRITE, PSEL, PENABLE, PREADY = 1'b0, PSLVERR = 1'b0, busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  apb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in(clk_in), .reset_int(reset_int),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Full transfer: accept, SETUP, ACCESS with `waits` stall cycles, RESP held `hold` cycles.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] prd, input bit slv, input int hold);
    int   psel_n = 0;
    int   pen_n  = 0;
    rsp_t e;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    sb.push_back('{rdata: (wr ? 32'd0 : prd), err: slv, to: 1'b0});
    tick();                                   // accept edge N
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr);
    chk("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, wdata);
    psel_n += PSEL; pen_n += PENABLE;
    tick();
    for (int w = 0; w <= waits; w++) begin
      // Stall cycles carry junk data and PSLVERR=1, which must be ignored.
      PREADY  = (w == waits);
      PRDATA  = (w == waits) ? prd : $urandom;
      PSLVERR = (w == waits) ? slv : 1'b1;
      chk("access_penable", PENABLE, 1);
      chk("access_paddr", PADDR, addr);
      chk("access_pwdata", PWDATA, wdata);
      chk("access_no_rsp", rsp_valid, 0);
      psel_n += PSEL; pen_n += PENABLE;
      tick();
    end
    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b1;
    chk("psel_cycles", psel_n, waits + 2);
    chk("penable_cycles", pen_n, waits + 1);
    chk("rsp_latency", rsp_valid, 1);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_busy", busy, 1);
    e = sb[0];
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, e.rdata);
      chk("hold_err", rsp_err, e.err);
      chk("hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("rsp_err", rsp_err, e.err);
    chk("rsp_timeout", rsp_timeout, e.to);
    void'(sb.pop_front());
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_paddr_kept", PADDR, addr);
    chk("post_pwrite_kept", PWRITE, wr);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk_in); #1;
    reset_int = 1'b1;
    tick();
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Zero-wait read
    xfer(1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    // Write with 3 wait states
    xfer(1'b1, 32'h0000_0004, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0, 0);
    // Read with slave error, response back-pressured 4 cycles
    xfer(1'b0, 32'h0000_0020, 32'h0, 0, 32'hA5A5_0001, 1'b1, 4);
    // Back-to-back-ish mixed traffic
    xfer(1'b1, 32'hFFFF_FFFC, 32'h8000_0001, 1, 32'h0, 1'b1, 1);
    xfer(1'b0, 32'h0000_0000, 32'h0, 2, 32'h0000_0000, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never answers: abort after 8 ACCESS cycles
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = '0;
    sb.push_back('{rdata: 32'd0, err: 1'b1, to: 1'b1});
    tick();
    cmd_valid = 1'b0;
    PREADY = 1'b0; PRDATA = 32'hBAD0_BAD0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_access_penable", PENABLE, 1);
      tick();
    end
    chk("to_psel_low", PSEL, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    chk("to_rdata", rsp_rdata, sb[0].rdata);
    chk("to_err", rsp_err, sb[0].err);
    chk("to_flag", rsp_timeout, sb[0].to);
    void'(sb.pop_front());
    tick();
    rsp_ready = 1'b0;
    // PREADY landing exactly on the timeout cycle is a normal completion
    xfer(1'b0, 32'h44, 32'h0, 7, 32'h0BAD_F00D, 1'b0, 0);
`else
    // Without the timeout, a long stall just keeps waiting
    xfer(1'b0, 32'h44, 32'h0, 20, 32'h0BAD_F00D, 1'b0, 0);
`endif

    // Reset during ACCESS aborts with no response
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_wdata = '0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("pre_abort_penable", PENABLE, 1);
    reset_int = 1'b0;
    #1;
    chk("abort_psel", PSEL, 0);
    chk("abort_penable", PENABLE, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_paddr", PADDR, 0);
    @(posedge clk_in); #1;
    reset_int = 1'b1;
    tick();
    chk("abort_no_rsp", rsp_valid, 0);
    xfer(1'b0, 32'h0000_0008, 32'h0, 0, 32'h0000_0055, 1'b0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound so the run can never hang.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535: consecutive ACCESS cycles with PREADY low before abort.
REQ-002 SHALL have ports clk_in  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have ports reset_int  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports cmd_valid  input  1, cmd_ready  output  1: command handshake.
REQ-005 SHALL have ports cmd_write  input  1, cmd_addr  input  32, cmd_wdata  input  32: command payload.
REQ-006 SHALL have ports rsp_valid  output  1, rsp_ready  input  1: response handshake.
REQ-007 SHALL have ports rsp_rdata  output  32, rsp_err  output  1, rsp_timeout  output  1: response payload.
REQ-008 SHALL have ports PADDR  output  32, PWDATA  output  32, PWRITE  output  1, PSEL  output  1, PENABLE  output  1: APB requester outputs.
REQ-009 SHALL have ports PRDATA  input  32, PREADY  input  1, PSLVERR  input  1: APB completer inputs.
REQ-010 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one outstanding transfer.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1, and the FSM moves to SETUP.
REQ-013 On acceptance, cmd_addr, cmd_wdata and cmd_write SHALL be registered into PADDR, PWDATA and PWRITE, which are held stable through SETUP and ACCESS.
REQ-014 In SETUP, PSEL=1 and PENABLE=0 for exactly one cycle; the next state is ACCESS unconditionally.
REQ-015 In ACCESS, PSEL=1 and PENABLE=1, held until PREADY=1 is sampled, or until timeout when enabled.
REQ-016 When PREADY=1 is sampled in ACCESS, the block SHALL capture PRDATA (reads only; writes give 0) into rsp_rdata and PSLVERR into rsp_err, set rsp_timeout=0, and enter RESP.
REQ-017 PSEL and PENABLE SHALL be 0 in IDLE and RESP.
REQ-018 In RESP, rsp_valid=1 with payload stable until rsp_ready=1 is sampled; the next state is IDLE.
REQ-019 Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3 (zero-wait completer); next accept no earlier than cycle N+4.
REQ-020 PADDR, PWDATA and PWRITE SHALL retain their last values in IDLE and RESP.
REQ-021 PRDATA and PSLVERR SHALL be ignored outside ACCESS, and whenever PREADY=0.

Reset
REQ-022 On reset_int low, asynchronously: state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0, timeout counter=0.
REQ-023 Reset asserted mid-transfer SHALL abort without a response; the first command after release is accepted normally.
REQ-024 cmd_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-025 Macro APB_MASTER_TIMEOUT_EN defined: a 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0; reaching TIMEOUT_CYCLES forces RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and PSEL/PENABLE low from the next cycle.
REQ-026 If PREADY=1 arrives in the same cycle the count reaches TIMEOUT_CYCLES, the block SHALL treat it as normal completion.
REQ-027 Macro not defined: no counter, ACCESS waits indefinitely, and rsp_timeout is tied to 0.

Verification
REQ-028 Read 0x0000_0010, PREADY=1 immediately, PRDATA=0xDEADBEEF -> rsp_valid in cycle N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-029 Write 0x0000_0004 with data 0x1234_5678, PREADY after 3 wait cycles -> PSEL high 5 cycles, PENABLE high 4 cycles, PWDATA stable, rsp_rdata=0.
REQ-030 Read with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0; rsp_ready held low 4 cycles -> payload stable and cmd_ready=0 throughout.
REQ-031 APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, PREADY tied 0 -> after 8 ACCESS cycles rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0 the next cycle.
REQ-032 reset_int pulsed low during ACCESS -> PSEL, PENABLE and rsp_valid drop to 0 immediately; a subsequent read of 0x8 with PRDATA=0x55 completes with rsp_rdata=0x55.
